// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the mode/switch logic, the intersection controller
// and the display driver. The controller uses the slave view; whoever drives
// the road inputs and reads the lights uses the master view.
interface traffic_phase_ctrl_if #(
  parameter int TW = 6
);
  logic          peak;
  logic          pause;
  logic          maint;
  logic          ped_m;
  logic          ped_s;
  logic [2:0]    main_light;
  logic [2:0]    sub_light;
  logic [TW-1:0] main_rest;
  logic [TW-1:0] sub_rest;
  logic          sec_tick;
  logic          paused;

  modport master (
    output peak, pause, maint, ped_m, ped_s,
    input  main_light, sub_light, main_rest, sub_rest, sec_tick, paused
  );

  modport slave (
    input  peak, pause, maint, ped_m, ped_s,
    output main_light, sub_light, main_rest, sub_rest, sec_tick, paused
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller. Sequences all-red / green / yellow
// phases for the main and sub roads from a one-second prescaler, drives the
// light codes and per-road countdowns, and supports pause, maintenance
// flashing and peak/off-peak green durations.
// Build option: define TLC_PED_EN to compile in the pedestrian request
// latches and the green early-cut; otherwise ped_m/ped_s are ignored.
module traffic_phase_ctrl #(
  parameter int CLOCK_HZ = 5,
  parameter int TW       = 6,
  parameter int GREEN_M  = 16,
  parameter int GREEN_S  = 10,
  parameter int PGREEN_M = 30,
  parameter int PGREEN_S = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_CUT  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int PW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLOCK_HZ - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [TW-1:0]   REM_ONE    = TW'(1);
  localparam logic [TW-1:0]   ALLRED_V   = TW'(ALLRED_T);
  localparam logic [TW-1:0]   PED_CUT_V  = TW'(PED_CUT);
  localparam logic [TW+1:0]   ADD_YA     = (TW+2)'(YELLOW_T + ALLRED_T);
  localparam logic [TW+1:0]   ADD_A      = (TW+2)'(ALLRED_T);
  localparam logic [TW+1:0]   REST_MAX   = {2'b00, {TW{1'b1}}};

  localparam logic [2:0] L_RED    = 3'd0;
  localparam logic [2:0] L_GREEN  = 3'd1;
  localparam logic [2:0] L_YELLOW = 3'd2;
  localparam logic [2:0] L_FLASH  = 3'd3;

  typedef enum logic [2:0] {AR_M, MG, MY, AR_S, SG, SY, FLASH} phase_e;

  phase_e        state_q, state_d;
  logic [TW-1:0] rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          paused_q, paused_d;
  logic [2:0]    main_light_q, main_light_d;
  logic [2:0]    sub_light_q, sub_light_d;
  logic [TW-1:0] main_rest_q, main_rest_d;
  logic [TW-1:0] sub_rest_q, sub_rest_d;
  logic          ped_m_q, ped_m_d;
  logic          ped_s_q, ped_s_d;
  logic          wrap;
  logic          cut;

  // Red-road countdown: widened add so the sum never wraps, then clamped.
  function automatic logic [TW-1:0] red_rest(input logic [TW-1:0] r,
                                             input logic [TW+1:0] extra);
    logic [TW+1:0] s;
    s = {2'b00, r} + extra;
    return (s > REST_MAX) ? {TW{1'b1}} : s[TW-1:0];
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      AR_M:    n = MG;
      MG:      n = MY;
      MY:      n = AR_S;
      AR_S:    n = SG;
      SG:      n = SY;
      default: n = AR_M;
    endcase
    return n;
  endfunction

  // Duration loaded on entry; peak is only looked at when a green starts.
  function automatic logic [TW-1:0] phase_dur(input phase_e p, input logic pk);
    logic [TW-1:0] d;
    case (p)
      MG:      d = pk ? TW'(PGREEN_M) : TW'(GREEN_M);
      SG:      d = pk ? TW'(PGREEN_S) : TW'(GREEN_S);
      MY, SY:  d = TW'(YELLOW_T);
      default: d = ALLRED_V;
    endcase
    return d;
  endfunction

`ifdef TLC_PED_EN
  // A request counts from the edge it is sampled on, and again later via the latch.
  assign cut = ((state_q == MG) && (ped_m_q || bus.ped_m) && (rem_q > PED_CUT_V)) ||
               ((state_q == SG) && (ped_s_q || bus.ped_s) && (rem_q > PED_CUT_V));
`else
  logic unused_ped;
  assign unused_ped = bus.ped_m | bus.ped_s | ped_m_q | ped_s_q;
  assign cut        = 1'b0;
`endif

  assign wrap = (presc_q == PRESC_LAST);

  // Next state, countdown, prescaler and pedestrian latches.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    rem_d    = rem_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    paused_d = 1'b0;
    ped_m_d  = 1'b0;
    ped_s_d  = 1'b0;

    if (bus.maint) begin
      state_d = FLASH;
      rem_d   = '0;
      presc_d = '0;
    end else if (bus.pause) begin
      paused_d = 1'b1;
    end else if (state_q == FLASH) begin
      state_d = AR_M;
      rem_d   = ALLRED_V;
      presc_d = '0;
    end else begin
      presc_d = wrap ? '0 : presc_q + PRESC_ONE;
      tick_d  = wrap;
      if (wrap && (rem_q == REM_ONE)) begin
        state_d = next_phase(state_q);
        rem_d   = phase_dur(state_d, bus.peak);
      end else if (cut) begin
        rem_d = PED_CUT_V;
      end else if (wrap) begin
        rem_d = rem_q - REM_ONE;
      end
    end

`ifdef TLC_PED_EN
    ped_m_d = (ped_m_q | bus.ped_m) & ~((state_q == MG) && (state_d != MG));
    ped_s_d = (ped_s_q | bus.ped_s) & ~((state_q == SG) && (state_d != SG));
`endif
  end

  // Output decode from the next state so outputs change on the same edge.
  always_comb begin
    main_light_d = L_RED;
    sub_light_d  = L_RED;
    main_rest_d  = '0;
    sub_rest_d   = '0;
    case (state_d)
      AR_M: main_rest_d = rem_d;
      MG: begin
        main_light_d = L_GREEN;
        main_rest_d  = rem_d;
        sub_rest_d   = red_rest(rem_d, ADD_YA);
      end
      MY: begin
        main_light_d = L_YELLOW;
        main_rest_d  = rem_d;
        sub_rest_d   = red_rest(rem_d, ADD_A);
      end
      AR_S: sub_rest_d = rem_d;
      SG: begin
        sub_light_d = L_GREEN;
        sub_rest_d  = rem_d;
        main_rest_d = red_rest(rem_d, ADD_YA);
      end
      SY: begin
        sub_light_d = L_YELLOW;
        sub_rest_d  = rem_d;
        main_rest_d = red_rest(rem_d, ADD_A);
      end
      FLASH: begin
        main_light_d = L_FLASH;
        sub_light_d  = L_FLASH;
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= AR_M;
      rem_q        <= ALLRED_V;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      paused_q     <= 1'b0;
      main_light_q <= L_RED;
      sub_light_q  <= L_RED;
      main_rest_q  <= ALLRED_V;
      sub_rest_q   <= '0;
      ped_m_q      <= 1'b0;
      ped_s_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      rem_q        <= rem_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      paused_q     <= paused_d;
      main_light_q <= main_light_d;
      sub_light_q  <= sub_light_d;
      main_rest_q  <= main_rest_d;
      sub_rest_q   <= sub_rest_d;
      ped_m_q      <= ped_m_d;
      ped_s_q      <= ped_s_d;
    end
  end

  assign bus.main_light = main_light_q;
  assign bus.sub_light  = sub_light_q;
  assign bus.main_rest  = main_rest_q;
  assign bus.sub_rest   = sub_rest_q;
  assign bus.sec_tick   = tick_q;
  assign bus.paused     = paused_q;

endmodule
